// File: rtl/inband_pkg.sv
// Shared inband packet definitions: header field layout, packet geometry, framer states.
package inband_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned PKT_WORDS   = 128;
    localparam int unsigned MAX_PAYLOAD = 504;
    localparam int unsigned CNT_W       = 7;

    // Header word 0 field positions
    localparam int unsigned CHAN_LSB = 16;
    localparam int unsigned CHAN_W   = 5;
    localparam int unsigned LEN_LSB  = 0;
    localparam int unsigned LEN_W    = 9;

    localparam logic [CHAN_W-1:0] CMD_CHAN = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } pkt_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/inband_hdr_check.sv
// Combinational inband header check: validity and target RAM index from word-0 fields.
module inband_hdr_check
    import inband_pkg::*;
#(
    parameter int unsigned NUM_CHAN = 1,
    parameter int unsigned TGT_W    = 1
) (
    input  logic [CHAN_W-1:0] chan,
    input  logic [LEN_W-1:0]  len,
    output logic              valid_c,
    output logic [TGT_W-1:0]  target_c
);

    logic is_cmd_c;
    logic is_data_c;
    logic len_ok_c;

    always_comb begin
        is_cmd_c  = (chan == CMD_CHAN);
        is_data_c = (32'(chan) < NUM_CHAN);
        len_ok_c  = (32'(len) <= MAX_PAYLOAD) && !len[0];
        valid_c   = len_ok_c && (is_cmd_c || is_data_c);
        // Command packets go to the RAM just past the data channels
        target_c  = is_cmd_c ? TGT_W'(NUM_CHAN) : TGT_W'(chan);
    end

endmodule

// File: rtl/tx_pkt_validator.sv
// Frames packer words into fixed-size inband packets, forwards valid ones to per-channel RAMs.
// Optional TX_PKT_VALIDATOR_STATS_EN adds saturating good/drop packet counters.
module tx_pkt_validator
    import inband_pkg::*;
#(
    parameter int unsigned NUM_CHAN = 1
) (
    input  logic              txclk,
    input  logic              reset,
    input  logic              flush,
    input  logic [WORD_W-1:0] data_in,
    input  logic              WR_in,
    output logic [WORD_W-1:0] data_out,
    output logic [NUM_CHAN:0] WR_channel,
    output logic [NUM_CHAN:0] WR_done_channel,
    output logic [NUM_CHAN:0] abort_channel,
    output logic              pkt_active,
    output logic              drop_pulse
`ifdef TX_PKT_VALIDATOR_STATS_EN
    ,
    output logic [15:0]       good_count,
    output logic [15:0]       drop_count
`endif
);

    localparam int unsigned NCH   = NUM_CHAN + 1;
    localparam int unsigned TGT_W = idx_width(NCH);

    pkt_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [TGT_W-1:0] tgt;
    logic [TGT_W-1:0] done_tgt;
    logic             done_pend;

    logic             hdr_valid_c;
    logic [TGT_W-1:0] hdr_tgt_c;
    logic             accept_c;
    logic             cnt_last_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             drop_set_c;

    function automatic logic [NUM_CHAN:0] onehot(input logic [TGT_W-1:0] idx);
        return NCH'(1) << idx;
    endfunction

    inband_hdr_check #(
        .NUM_CHAN (NUM_CHAN),
        .TGT_W    (TGT_W)
    ) u_hdr_check (
        .chan     (data_in[CHAN_LSB +: CHAN_W]),
        .len      (data_in[LEN_LSB +: LEN_W]),
        .valid_c  (hdr_valid_c),
        .target_c (hdr_tgt_c)
    );

    assign accept_c   = WR_in && !flush;
    assign cnt_last_c = (cnt == CNT_W'(PKT_WORDS - 1));
    assign cnt_inc_c  = cnt_last_c ? '0 : cnt + CNT_W'(1);
    assign drop_set_c = accept_c && (state == IDLE) && !hdr_valid_c;

    // Framer FSM with registered strobes; done is delayed one extra cycle behind the last write
    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            tgt             <= '0;
            done_tgt        <= '0;
            done_pend       <= 1'b0;
            data_out        <= '0;
            WR_channel      <= '0;
            WR_done_channel <= '0;
            abort_channel   <= '0;
            pkt_active      <= 1'b0;
            drop_pulse      <= 1'b0;
        end else begin
            WR_channel      <= '0;
            WR_done_channel <= '0;
            abort_channel   <= '0;
            drop_pulse      <= 1'b0;
            done_pend       <= 1'b0;

            if (done_pend) begin
                WR_done_channel <= onehot(done_tgt);
            end

            if (flush) begin
                if (state == FWD) begin
                    abort_channel <= onehot(tgt);
                end
                state      <= IDLE;
                cnt        <= '0;
                pkt_active <= 1'b0;
            end else if (accept_c) begin
                cnt        <= cnt_inc_c;
                pkt_active <= (cnt_inc_c != '0);
                case (state)
                    IDLE: begin
                        if (hdr_valid_c) begin
                            state      <= FWD;
                            tgt        <= hdr_tgt_c;
                            data_out   <= data_in;
                            WR_channel <= onehot(hdr_tgt_c);
                        end else begin
                            state      <= DROP;
                            drop_pulse <= 1'b1;
                        end
                    end
                    FWD: begin
                        data_out   <= data_in;
                        WR_channel <= onehot(tgt);
                        if (cnt_last_c) begin
                            state     <= IDLE;
                            done_pend <= 1'b1;
                            done_tgt  <= tgt;
                        end
                    end
                    DROP: begin
                        if (cnt_last_c) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef TX_PKT_VALIDATOR_STATS_EN
    // Saturating packet statistics; survive flush, cleared only by reset
    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            good_count <= '0;
            drop_count <= '0;
        end else begin
            if (done_pend && (good_count != 16'hFFFF)) begin
                good_count <= good_count + 16'd1;
            end
            if (drop_set_c && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tx_pkt_validator.sv
// Directed bench for tx_pkt_validator with NUM_CHAN=1 (bit 0 data channel, bit 1 command RAM).
module tb_tx_pkt_validator;

    localparam int unsigned NUM_CHAN = 1;
    localparam int CAP_DEPTH = 4096;

    localparam logic [31:0] H_D504  = 32'h0000_01F8;  // chan 0, len 504
    localparam logic [31:0] H_C8    = 32'h001F_0008;  // command, len 8
    localparam logic [31:0] H_L506  = 32'h0000_01FA;  // len too large
    localparam logic [31:0] H_L7    = 32'h0000_0007;  // odd len
    localparam logic [31:0] H_CH5   = 32'h0005_0008;  // chan out of range
    localparam logic [31:0] H_CH1   = 32'h0001_0008;  // chan == NUM_CHAN
    localparam logic [31:0] H_D16X  = 32'hDEA0_1010;  // chan 0, len 16, junk in unchecked bits

    logic              txclk;
    logic              reset;
    logic              flush;
    logic [31:0]       data_in;
    logic              WR_in;
    logic [31:0]       data_out;
    logic [NUM_CHAN:0] WR_channel;
    logic [NUM_CHAN:0] WR_done_channel;
    logic [NUM_CHAN:0] abort_channel;
    logic              pkt_active;
    logic              drop_pulse;
`ifdef TX_PKT_VALIDATOR_STATS_EN
    logic [15:0]       good_count;
    logic [15:0]       drop_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    int wr0_n = 0, wr1_n = 0, done0_n = 0, done1_n = 0;
    int abort0_n = 0, abort1_n = 0, drop_n = 0, coin_n = 0;
    int last_wr_cyc = 0, last_done_cyc = 0, cap_n = 0;
    logic [31:0] cap_data [0:CAP_DEPTH-1];
    int          cap_cyc  [0:CAP_DEPTH-1];
    logic [31:0] exp_q [$];
    int last_acc = 0;

    int b_wr0, b_wr1, b_done0, b_done1, b_ab0, b_ab1, b_drop, b_coin, b_cap;

    tx_pkt_validator #(.NUM_CHAN(NUM_CHAN)) dut (
        .txclk           (txclk),
        .reset           (reset),
        .flush           (flush),
        .data_in         (data_in),
        .WR_in           (WR_in),
        .data_out        (data_out),
        .WR_channel      (WR_channel),
        .WR_done_channel (WR_done_channel),
        .abort_channel   (abort_channel),
        .pkt_active      (pkt_active),
        .drop_pulse      (drop_pulse)
`ifdef TX_PKT_VALIDATOR_STATS_EN
        ,
        .good_count      (good_count),
        .drop_count      (drop_count)
`endif
    );

    initial begin
        txclk = 1'b0;
        forever #5 txclk = ~txclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge txclk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge
    always @(negedge txclk) begin
        if (WR_channel[0])      wr0_n    <= wr0_n + 1;
        if (WR_channel[1])      wr1_n    <= wr1_n + 1;
        if (WR_done_channel[0]) done0_n  <= done0_n + 1;
        if (WR_done_channel[1]) done1_n  <= done1_n + 1;
        if (abort_channel[0])   abort0_n <= abort0_n + 1;
        if (abort_channel[1])   abort1_n <= abort1_n + 1;
        if (drop_pulse)         drop_n   <= drop_n + 1;
        if (WR_channel != '0) begin
            if (cap_n < CAP_DEPTH) begin
                cap_data[cap_n] <= data_out;
                cap_cyc[cap_n]  <= cyc;
            end
            cap_n       <= cap_n + 1;
            last_wr_cyc <= cyc;
        end
        if (WR_done_channel != '0) last_done_cyc <= cyc;
        if ((WR_done_channel != '0) && (WR_channel != '0)) coin_n <= coin_n + 1;
    end

    task automatic drive(input logic wr, input logic [31:0] d, input logic fl);
        @(negedge txclk);
        WR_in   = wr;
        data_in = d;
        flush   = fl;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 32'h0, 1'b0);
    endtask

    task automatic snap();
        b_wr0 = wr0_n;   b_wr1 = wr1_n;   b_done0 = done0_n; b_done1 = done1_n;
        b_ab0 = abort0_n; b_ab1 = abort1_n; b_drop = drop_n;  b_coin = coin_n;
        b_cap = cap_n;
    endtask

    task automatic send_pkt(input logic [31:0] hdr, input logic [31:0] seed,
                            input int gap_pct, input bit fwd);
        for (int i = 0; i < 128; i++) begin
            logic [31:0] w;
            w = (i == 0) ? hdr : seed + 32'(i);
            if ((i != 0) && (gap_pct > 0) && (int'($urandom_range(99)) < gap_pct))
                drive(1'b0, 32'h0, 1'b0);
            drive(1'b1, w, 1'b0);
            last_acc = cyc + 1;
            if (fwd) exp_q.push_back(w);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; WR_in = 1'b0; data_in = 32'h0;
        repeat (3) @(negedge txclk);
        n_cmp++; if (data_out !== 32'h0) begin n_bad++; $display("FAIL reset data_out: got %h want 0", data_out); end
        n_cmp++; if (WR_channel !== 2'b00) begin n_bad++; $display("FAIL reset WR_channel: got %b want 00", WR_channel); end
        n_cmp++; if (WR_done_channel !== 2'b00) begin n_bad++; $display("FAIL reset WR_done: got %b want 00", WR_done_channel); end
        n_cmp++; if (abort_channel !== 2'b00) begin n_bad++; $display("FAIL reset abort: got %b want 00", abort_channel); end
        n_cmp++; if ({pkt_active, drop_pulse} !== 2'b00) begin n_bad++; $display("FAIL reset active/drop: got %b want 00", {pkt_active, drop_pulse}); end
        reset = 1'b1;
        idle(2);
    endtask

    task automatic test_data_pkt();
        logic [31:0] seed;
        int acc0;
        seed = 32'hA500_0000;
        exp_q.delete();
        snap();
        drive(1'b1, H_D504, 1'b0);
        acc0 = cyc + 1;
        exp_q.push_back(H_D504);
        drive(1'b1, seed + 32'd1, 1'b0);
        exp_q.push_back(seed + 32'd1);
        n_cmp++; if (pkt_active !== 1'b1) begin n_bad++; $display("FAIL data_pkt pkt_active: got %b want 1", pkt_active); end
        n_cmp++; if (WR_channel !== 2'b01) begin n_bad++; $display("FAIL data_pkt first WR: got %b want 01", WR_channel); end
        n_cmp++; if (data_out !== H_D504) begin n_bad++; $display("FAIL data_pkt first data: got %h want %h", data_out, H_D504); end
        for (int i = 2; i < 128; i++) begin
            drive(1'b1, seed + 32'(i), 1'b0);
            exp_q.push_back(seed + 32'(i));
        end
        last_acc = cyc + 1;
        idle(4);
        n_cmp++; if (wr0_n - b_wr0 !== 128) begin n_bad++; $display("FAIL data_pkt wr0 count: got %0d want 128", wr0_n - b_wr0); end
        n_cmp++; if (wr1_n - b_wr1 !== 0) begin n_bad++; $display("FAIL data_pkt wr1 count: got %0d want 0", wr1_n - b_wr1); end
        n_cmp++; if (done0_n - b_done0 !== 1) begin n_bad++; $display("FAIL data_pkt done0 count: got %0d want 1", done0_n - b_done0); end
        n_cmp++; if (cap_cyc[b_cap] !== acc0) begin n_bad++; $display("FAIL data_pkt write latency: got cycle %0d want %0d", cap_cyc[b_cap], acc0); end
        n_cmp++; if (last_done_cyc !== last_acc + 1) begin n_bad++; $display("FAIL data_pkt done latency: got cycle %0d want %0d", last_done_cyc, last_acc + 1); end
        n_cmp++; if (pkt_active !== 1'b0) begin n_bad++; $display("FAIL data_pkt pkt_active end: got %b want 0", pkt_active); end
        for (int i = 0; i < 128; i++) begin
            n_cmp++;
            if (cap_data[b_cap + i] !== exp_q[i]) begin
                n_bad++; $display("FAIL data_pkt word %0d: got %h want %h", i, cap_data[b_cap + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_cmd_pkt();
        snap();
        send_pkt(H_C8, 32'hC000_0000, 0, 1'b0);
        idle(4);
        n_cmp++; if (wr1_n - b_wr1 !== 128) begin n_bad++; $display("FAIL cmd_pkt wr1 count: got %0d want 128", wr1_n - b_wr1); end
        n_cmp++; if (wr0_n - b_wr0 !== 0) begin n_bad++; $display("FAIL cmd_pkt wr0 count: got %0d want 0", wr0_n - b_wr0); end
        n_cmp++; if (done1_n - b_done1 !== 1) begin n_bad++; $display("FAIL cmd_pkt done1 count: got %0d want 1", done1_n - b_done1); end
        n_cmp++; if (done0_n - b_done0 !== 0) begin n_bad++; $display("FAIL cmd_pkt done0 count: got %0d want 0", done0_n - b_done0); end
        n_cmp++; if (cap_data[cap_n - 1] !== 32'hC000_007F) begin n_bad++; $display("FAIL cmd_pkt last word: got %h want C000007F", cap_data[cap_n - 1]); end
    endtask

    task automatic test_invalid_hdrs();
        logic [31:0] bad_hdr [4];
        bad_hdr[0] = H_L506; bad_hdr[1] = H_L7; bad_hdr[2] = H_CH5; bad_hdr[3] = H_CH1;
        for (int p = 0; p < 4; p++) begin
            snap();
            send_pkt(bad_hdr[p], 32'hBAD0_0000, 0, 1'b0);
            idle(3);
            n_cmp++; if (drop_n - b_drop !== 1) begin n_bad++; $display("FAIL invalid hdr %h drop count: got %0d want 1", bad_hdr[p], drop_n - b_drop); end
            n_cmp++; if (cap_n - b_cap !== 0) begin n_bad++; $display("FAIL invalid hdr %h writes: got %0d want 0", bad_hdr[p], cap_n - b_cap); end
            n_cmp++; if ((done0_n - b_done0) + (done1_n - b_done1) !== 0) begin n_bad++; $display("FAIL invalid hdr %h done pulses: got %0d want 0", bad_hdr[p], (done0_n - b_done0) + (done1_n - b_done1)); end
        end
        exp_q.delete();
        snap();
        send_pkt(H_D16X, 32'h1234_0000, 0, 1'b1);
        idle(4);
        n_cmp++; if (wr0_n - b_wr0 !== 128) begin n_bad++; $display("FAIL after_invalid wr0 count: got %0d want 128", wr0_n - b_wr0); end
        n_cmp++; if (done0_n - b_done0 !== 1) begin n_bad++; $display("FAIL after_invalid done0 count: got %0d want 1", done0_n - b_done0); end
        n_cmp++; if (drop_n - b_drop !== 0) begin n_bad++; $display("FAIL after_invalid drop count: got %0d want 0", drop_n - b_drop); end
        n_cmp++; if (cap_data[b_cap] !== H_D16X) begin n_bad++; $display("FAIL after_invalid header word: got %h want %h", cap_data[b_cap], H_D16X); end
        n_cmp++; if (cap_data[b_cap + 127] !== 32'h1234_007F) begin n_bad++; $display("FAIL after_invalid last word: got %h want 1234007F", cap_data[b_cap + 127]); end
    endtask

    task automatic test_flush();
        logic [31:0] seed;
        seed = 32'hF100_0000;
        snap();
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 60; i++) drive(1'b1, (i == 0) ? H_D504 : seed + 32'(i), 1'b0);
        drive(1'b1, seed + 32'd60, 1'b1);
        idle(4);
        n_cmp++; if (wr0_n - b_wr0 !== 60) begin n_bad++; $display("FAIL flush wr0 count: got %0d want 60", wr0_n - b_wr0); end
        n_cmp++; if (abort0_n - b_ab0 !== 1) begin n_bad++; $display("FAIL flush abort0 count: got %0d want 1", abort0_n - b_ab0); end
        n_cmp++; if (abort1_n - b_ab1 !== 0) begin n_bad++; $display("FAIL flush abort1 count: got %0d want 0", abort1_n - b_ab1); end
        n_cmp++; if (done0_n - b_done0 !== 0) begin n_bad++; $display("FAIL flush done0 count: got %0d want 0", done0_n - b_done0); end
        n_cmp++; if (cap_data[cap_n - 1] !== seed + 32'd59) begin n_bad++; $display("FAIL flush last forwarded: got %h want %h", cap_data[cap_n - 1], seed + 32'd59); end
        n_cmp++; if (pkt_active !== 1'b0) begin n_bad++; $display("FAIL flush pkt_active: got %b want 0", pkt_active); end

        snap();
        send_pkt(H_C8, 32'hC100_0000, 0, 1'b0);
        idle(4);
        n_cmp++; if (wr1_n - b_wr1 !== 128) begin n_bad++; $display("FAIL post_flush wr1 count: got %0d want 128", wr1_n - b_wr1); end
        n_cmp++; if (done1_n - b_done1 !== 1) begin n_bad++; $display("FAIL post_flush done1 count: got %0d want 1", done1_n - b_done1); end

        snap();
        for (int i = 0; i < 10; i++) drive(1'b1, (i == 0) ? H_L7 : 32'h5555_0000 + 32'(i), 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        idle(3);
        send_pkt(H_D504, 32'hD200_0000, 0, 1'b0);
        idle(4);
        n_cmp++; if (drop_n - b_drop !== 1) begin n_bad++; $display("FAIL drop_flush drop count: got %0d want 1", drop_n - b_drop); end
        n_cmp++; if ((abort0_n - b_ab0) + (abort1_n - b_ab1) !== 0) begin n_bad++; $display("FAIL drop_flush aborts: got %0d want 0", (abort0_n - b_ab0) + (abort1_n - b_ab1)); end
        n_cmp++; if (wr0_n - b_wr0 !== 128) begin n_bad++; $display("FAIL drop_flush wr0 count: got %0d want 128", wr0_n - b_wr0); end
        n_cmp++; if (done0_n - b_done0 !== 1) begin n_bad++; $display("FAIL drop_flush done0 count: got %0d want 1", done0_n - b_done0); end
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        snap();
        send_pkt(H_D504, 32'h1000_0000, 30, 1'b1);
        send_pkt(H_C8,   32'h2000_0000, 30, 1'b1);
        send_pkt(H_D16X, 32'h3000_0000, 30, 1'b1);
        idle(4);
        n_cmp++; if (wr0_n - b_wr0 !== 256) begin n_bad++; $display("FAIL b2b wr0 count: got %0d want 256", wr0_n - b_wr0); end
        n_cmp++; if (wr1_n - b_wr1 !== 128) begin n_bad++; $display("FAIL b2b wr1 count: got %0d want 128", wr1_n - b_wr1); end
        n_cmp++; if (done0_n - b_done0 !== 2) begin n_bad++; $display("FAIL b2b done0 count: got %0d want 2", done0_n - b_done0); end
        n_cmp++; if (done1_n - b_done1 !== 1) begin n_bad++; $display("FAIL b2b done1 count: got %0d want 1", done1_n - b_done1); end
        n_cmp++; if (coin_n - b_coin !== 2) begin n_bad++; $display("FAIL b2b done/WR overlap: got %0d want 2", coin_n - b_coin); end
        n_cmp++; if (cap_n - b_cap !== 384) begin n_bad++; $display("FAIL b2b captured words: got %0d want 384", cap_n - b_cap); end
        for (int i = 0; i < 384; i++) begin
            n_cmp++;
            if (cap_data[b_cap + i] !== exp_q[i]) begin
                n_bad++; $display("FAIL b2b word %0d: got %h want %h", i, cap_data[b_cap + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 20; i++) drive(1'b1, (i == 0) ? H_D504 : 32'h7700_0000 + 32'(i), 1'b0);
        @(posedge txclk);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (WR_channel !== 2'b00) begin n_bad++; $display("FAIL async_reset WR_channel: got %b want 00", WR_channel); end
        n_cmp++; if (data_out !== 32'h0) begin n_bad++; $display("FAIL async_reset data_out: got %h want 0", data_out); end
        n_cmp++; if (pkt_active !== 1'b0) begin n_bad++; $display("FAIL async_reset pkt_active: got %b want 0", pkt_active); end
        @(negedge txclk);
        WR_in = 1'b0; data_in = 32'h0;
        @(negedge txclk);
        reset = 1'b1;
        snap();
        send_pkt(H_C8, 32'h8800_0000, 0, 1'b0);
        idle(4);
        n_cmp++; if (wr1_n - b_wr1 !== 128) begin n_bad++; $display("FAIL post_reset wr1 count: got %0d want 128", wr1_n - b_wr1); end
        n_cmp++; if (wr0_n - b_wr0 !== 0) begin n_bad++; $display("FAIL post_reset wr0 count: got %0d want 0", wr0_n - b_wr0); end
        n_cmp++; if (done1_n - b_done1 !== 1) begin n_bad++; $display("FAIL post_reset done1 count: got %0d want 1", done1_n - b_done1); end
        n_cmp++; if ((abort0_n - b_ab0) + (abort1_n - b_ab1) !== 0) begin n_bad++; $display("FAIL post_reset aborts: got %0d want 0", (abort0_n - b_ab0) + (abort1_n - b_ab1)); end
    endtask

`ifdef TX_PKT_VALIDATOR_STATS_EN
    task automatic test_stats();
        @(negedge txclk);
        reset = 1'b0;
        @(negedge txclk);
        n_cmp++; if (good_count !== 16'd0) begin n_bad++; $display("FAIL stats good after reset: got %0d want 0", good_count); end
        n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL stats drop after reset: got %0d want 0", drop_count); end
        reset = 1'b1;
        send_pkt(H_D504, 32'h9100_0000, 0, 1'b0);
        send_pkt(H_L7,   32'h9200_0000, 0, 1'b0);
        send_pkt(H_C8,   32'h9300_0000, 0, 1'b0);
        send_pkt(H_CH5,  32'h9400_0000, 0, 1'b0);
        send_pkt(H_D16X, 32'h9500_0000, 0, 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        idle(4);
        n_cmp++; if (good_count !== 16'd3) begin n_bad++; $display("FAIL stats good_count: got %0d want 3", good_count); end
        n_cmp++; if (drop_count !== 16'd2) begin n_bad++; $display("FAIL stats drop_count: got %0d want 2", drop_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_data_pkt();
        test_cmd_pkt();
        test_invalid_hdrs();
        test_flush();
        test_back_to_back();
        test_async_reset();
`ifdef TX_PKT_VALIDATOR_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
